// File: rtl/fle_fabric_regbank.sv
// fle_fabric_regbank: registered-output stage of the fracturable logic element
// fabric. Each channel either registers its frac-logic output or bypasses it
// straight to fabric_out; a serial configuration chain holds per-channel
// output-select and reset-value bits, and all channel FFs form one scan chain.
//
// Optional feature: define FLE_FABRIC_CFG_CHECK_EN to add a shift-length
// checker on the configuration window (cfg_done / cfg_err ports).
module fle_fabric_regbank #(
  parameter int NUM_CH = 2
) (
  input  logic              fabric_clk,
  input  logic              pReset,
  input  logic              config_enable,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic              Test_en,
  input  logic              fabric_sc_in,
  output logic              fabric_sc_out,
  input  logic              fabric_reset,
  input  logic              fabric_ce,
  input  logic [NUM_CH-1:0] fabric_d,
`ifdef FLE_FABRIC_CFG_CHECK_EN
  output logic              cfg_done,
  output logic              cfg_err,
`endif
  output logic [NUM_CH-1:0] fabric_out
);

  localparam int CHAIN_LEN = 2 * NUM_CH;

  logic [CHAIN_LEN-1:0] cfg;
  logic [NUM_CH-1:0]    ff;
  logic [NUM_CH-1:0]    out_sel;
  logic [NUM_CH-1:0]    rst_val;
  logic [NUM_CH-1:0]    scan_next;

  // Unpack the interleaved config bits and form the scan-shifted FF vector
  always_comb begin
    out_sel   = '0;
    rst_val   = '0;
    scan_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      out_sel[c] = cfg[2*c];
      rst_val[c] = cfg[2*c+1];
    end
    scan_next[0] = fabric_sc_in;
    for (int c = 1; c < NUM_CH; c++) begin
      scan_next[c] = ff[c-1];
    end
  end

  // Configuration chain: shifts toward the tail only while config_enable is high
  always_ff @(posedge fabric_clk or negedge pReset) begin
    if (!pReset) begin
      cfg <= '0;
    end else if (config_enable) begin
      cfg <= {cfg[CHAIN_LEN-2:0], ccff_head};
    end
  end

  // Channel FFs: configuration freezes them, then scan, user reset, clock enable
  always_ff @(posedge fabric_clk or negedge pReset) begin
    if (!pReset) begin
      ff <= '0;
    end else if (!config_enable) begin
      if (Test_en) begin
        ff <= scan_next;
      end else if (fabric_reset) begin
        ff <= rst_val;
      end else if (fabric_ce) begin
        ff <= fabric_d;
      end
    end
  end

  assign ccff_tail     = cfg[CHAIN_LEN-1];
  assign fabric_sc_out = ff[NUM_CH-1];

  // Output mux; gated to zero during reset and while the config is being loaded
  // so the crossbar never sees half-shifted selects
  always_comb begin
    fabric_out = '0;
    if (pReset && !config_enable) begin
      fabric_out = (out_sel & ff) | (~out_sel & fabric_d);
    end
  end

`ifdef FLE_FABRIC_CFG_CHECK_EN
  localparam int CNT_W = $clog2(CHAIN_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

  // Saturating increment: any window longer than the chain reads as CHAIN_LEN+1
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

  logic             cfg_en_q;
  logic [CNT_W-1:0] cnt;

  // Window length checker; the opening shift cycle counts as the first shift
  always_ff @(posedge fabric_clk or negedge pReset) begin
    if (!pReset) begin
      cfg_en_q <= 1'b0;
      cnt      <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_en_q <= config_enable;
      if (config_enable && !cfg_en_q) begin
        cnt      <= CNT_W'(1);
        cfg_done <= 1'b0;
        cfg_err  <= 1'b0;
      end else if (config_enable) begin
        cnt <= sat_inc(cnt);
      end else if (cfg_en_q) begin
        cfg_done <= (cnt == CNT_FULL);
        cfg_err  <= (cnt != CNT_FULL);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fle_fabric_regbank.sv
// Testbench for fle_fabric_regbank (NUM_CH=2): directed literal checks followed
// by randomized traffic compared every cycle against a queue-based model.
module tb_fle_fabric_regbank;

  localparam int NUM_CH    = 2;
  localparam int CHAIN_LEN = 2 * NUM_CH;

  logic              fabric_clk;
  logic              pReset;
  logic              config_enable;
  logic              ccff_head;
  logic              ccff_tail;
  logic              Test_en;
  logic              fabric_sc_in;
  logic              fabric_sc_out;
  logic              fabric_reset;
  logic              fabric_ce;
  logic [NUM_CH-1:0] fabric_d;
  logic [NUM_CH-1:0] fabric_out;
`ifdef FLE_FABRIC_CFG_CHECK_EN
  logic              cfg_done;
  logic              cfg_err;
`endif

  fle_fabric_regbank #(.NUM_CH(NUM_CH)) dut (
    .fabric_clk    (fabric_clk),
    .pReset        (pReset),
    .config_enable (config_enable),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .Test_en       (Test_en),
    .fabric_sc_in  (fabric_sc_in),
    .fabric_sc_out (fabric_sc_out),
    .fabric_reset  (fabric_reset),
    .fabric_ce     (fabric_ce),
    .fabric_d      (fabric_d),
`ifdef FLE_FABRIC_CFG_CHECK_EN
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
`endif
    .fabric_out    (fabric_out)
  );

  initial fabric_clk = 1'b0;
  always #5 fabric_clk = ~fabric_clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cfg as a queue of shifted-in bits (index i = cfg[i]),
  // channel FFs as a queue (index c = ff[c]), window length as a plain count.
  bit m_cfg[$];
  bit m_ff[$];
  int m_cnt;
  bit m_in_win, m_done, m_err;

  task automatic model_reset();
    m_cfg.delete();
    m_ff.delete();
    repeat (CHAIN_LEN) m_cfg.push_back(1'b0);
    repeat (NUM_CH) m_ff.push_back(1'b0);
    m_cnt    = 0;
    m_in_win = 0;
    m_done   = 0;
    m_err    = 0;
  endtask

  always @(posedge fabric_clk or negedge pReset) begin
    if (!pReset) begin
      model_reset();
    end else if (config_enable) begin
      if (!m_in_win) begin
        m_cnt  = 0;
        m_done = 0;
        m_err  = 0;
      end
      m_in_win = 1;
      m_cnt++;
      m_cfg.push_front(ccff_head);
      void'(m_cfg.pop_back());
    end else begin
      if (m_in_win) begin
        m_done = (m_cnt == CHAIN_LEN);
        m_err  = !m_done;
      end
      m_in_win = 0;
      if (Test_en) begin
        m_ff.push_front(fabric_sc_in);
        void'(m_ff.pop_back());
      end else if (fabric_reset) begin
        for (int c = 0; c < NUM_CH; c++) m_ff[c] = m_cfg[2*c+1];
      end else if (fabric_ce) begin
        for (int c = 0; c < NUM_CH; c++) m_ff[c] = fabric_d[c];
      end
    end
  end

  function automatic logic [NUM_CH-1:0] exp_out();
    logic [NUM_CH-1:0] r;
    r = '0;
    if (pReset && !config_enable) begin
      for (int c = 0; c < NUM_CH; c++) r[c] = m_cfg[2*c] ? m_ff[c] : fabric_d[c];
    end
    return r;
  endfunction

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge fabric_clk) begin
    if (cmp_on) begin
      chk("model_out", fabric_out, exp_out());
      chk("model_tail", ccff_tail, m_cfg[CHAIN_LEN-1]);
      chk("model_scout", fabric_sc_out, m_ff[NUM_CH-1]);
`ifdef FLE_FABRIC_CFG_CHECK_EN
      chk("model_done", cfg_done, m_done);
      chk("model_err", cfg_err, m_err);
`endif
    end
  end

  task automatic tick();
    @(posedge fabric_clk);
    #2;
  endtask

`ifdef FLE_FABRIC_CFG_CHECK_EN
  task automatic window(input int n, input bit exp_done);
    tick();
    config_enable = 1'b1;
    repeat (n) begin
      ccff_head = 1'($urandom);
      tick();
    end
    config_enable = 1'b0;
    tick();
    #1;
    chk("win_done", cfg_done, exp_done);
    chk("win_err", cfg_err, !exp_done);
  endtask
`endif

  initial begin
    model_reset();
    pReset        = 1'b0;
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    Test_en       = 1'b0;
    fabric_sc_in  = 1'b0;
    fabric_reset  = 1'b0;
    fabric_ce     = 1'b0;
    fabric_d      = 2'b11;
    repeat (2) tick();
    cmp_on = 1;

    // Reset state
    #1;
    chk("rst_out", fabric_out, 2'b00);
    chk("rst_tail", ccff_tail, 1'b0);
    chk("rst_scout", fabric_sc_out, 1'b0);
`ifdef FLE_FABRIC_CFG_CHECK_EN
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
`endif

    // Bypass after release with cfg=0
    tick();
    pReset = 1'b1;
    #1 chk("bypass_11", fabric_out, 2'b11);
    fabric_d = 2'b01;
    #1 chk("bypass_01", fabric_out, 2'b01);

    // Config load 1,1,0,1 -> cfg=1101
    tick();
    config_enable = 1'b1;
    ccff_head     = 1'b1;
    #1 chk("cfg_gate0", fabric_out, 2'b00);
    tick();
    ccff_head = 1'b1;
    #1 chk("cfg_gate1", fabric_out, 2'b00);
    tick();
    ccff_head = 1'b0;
    tick();
    ccff_head = 1'b1;
    tick();
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    #1;
    chk("cfg_tail", ccff_tail, 1'b1);
    chk("cfg_regout", fabric_out, 2'b00);
    tick();
`ifdef FLE_FABRIC_CFG_CHECK_EN
    #1;
    chk("cfg4_done", cfg_done, 1'b1);
    chk("cfg4_err", cfg_err, 1'b0);
`endif

    // User path: one-cycle latency, then reset value overrides ce
    fabric_ce = 1'b1;
    fabric_d  = 2'b10;
    #1 chk("ce_same_cycle", fabric_out, 2'b00);
    tick();
    #1 chk("ce_10", fabric_out, 2'b10);
    fabric_d = 2'b01;
    tick();
    #1 chk("ce_01", fabric_out, 2'b01);
    fabric_reset = 1'b1;
    fabric_d     = 2'b11;
    tick();
    #1 chk("rst_val", fabric_out, 2'b10);
    fabric_reset = 1'b0;
    fabric_d     = 2'b01;
    tick();
    #1 chk("ce_reload", fabric_out, 2'b01);

    // Scan with a competing user reset
    fabric_ce    = 1'b0;
    Test_en      = 1'b1;
    fabric_reset = 1'b1;
    fabric_sc_in = 1'b1;
    tick();
    fabric_sc_in = 1'b0;
    tick();
    Test_en      = 1'b0;
    fabric_reset = 1'b0;
    #1;
    chk("scan_ff", fabric_out, 2'b10);
    chk("scan_out1", fabric_sc_out, 1'b1);
    Test_en      = 1'b1;
    fabric_reset = 1'b1;
    fabric_sc_in = 1'b1;
    tick();
    Test_en      = 1'b0;
    fabric_reset = 1'b0;
    #1;
    chk("scan_prio", fabric_out, 2'b01);
    chk("scan_out0", fabric_sc_out, 1'b0);

    // Freeze and resume without a shift
    config_enable = 1'b1;
    #1 chk("freeze_gate", fabric_out, 2'b00);
    config_enable = 1'b0;
    #1 chk("freeze_resume", fabric_out, 2'b01);

`ifdef FLE_FABRIC_CFG_CHECK_EN
    window(3, 1'b0);
    window(7, 1'b0);
    window(4, 1'b1);
    pReset = 1'b0;
    #1;
    chk("pulse_done", cfg_done, 1'b0);
    chk("pulse_err", cfg_err, 1'b0);
    pReset = 1'b1;
`endif

    // Randomized traffic, checked each cycle by the compare process
    repeat (3000) begin
      tick();
      if ($urandom_range(0, 99) < 12) config_enable = ~config_enable;
      pReset       = ($urandom_range(0, 199) != 0);
      Test_en      = ($urandom_range(0, 9) == 0);
      fabric_reset = ($urandom_range(0, 7) == 0);
      fabric_ce    = 1'($urandom);
      fabric_d     = NUM_CH'($urandom);
      fabric_sc_in = 1'($urandom);
      ccff_head    = 1'($urandom);
    end
    tick();
    @(posedge fabric_clk);
    #7;
    cmp_on = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
